// File: rtl/ex_div_sequencer.sv
// RV32M divide sequencer for the EX stage: radix-2 restoring divider that holds
// the pipeline while iterating and hands back a sign-corrected result plus rd.
module ex_div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d, ord_q, ord_d;
  logic            negq_q, negq_d, negr_q, negr_d;
  logic [XLEN-1:0] out_q, out_d;

  logic            sgn, s1, s2;
  logic [XLEN-1:0] a_abs, b_abs, rem_nx, quo_nx, res_sel;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            ge;

  always_comb begin
    sgn   = ~op_i[0];
    s1    = sgn & rs1_i[XLEN-1];
    s2    = sgn & rs2_i[XLEN-1];
    a_abs = s1 ? -rs1_i : rs1_i;
    b_abs = s2 ? -rs2_i : rs2_i;
    // Full-width partial remainder so the top shifted-out bit takes part in the compare.
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    ge      = rem_sh >= {1'b0, dvs_q};
    rem_sub = rem_sh - {1'b0, dvs_q};
    rem_nx  = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    op_d    = op_q;
    rd_d    = rd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      S_IDLE: if (start_i && !flush_i) begin
        op_d   = op_i;
        rd_d   = rd_addr_i;
        negq_d = s1 ^ s2;
        negr_d = s1;
        if (rs2_i == '0) begin
          quo_d   = '1;
          rem_d   = rs1_i;
          state_d = S_DONE;
        end else if (sgn && rs1_i == {1'b1, {(XLEN-1){1'b0}}} && rs2_i == '1) begin
          quo_d   = {1'b1, {(XLEN-1){1'b0}}};
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          rem_d   = '0;
          quo_d   = a_abs;
          dvs_d   = b_abs;
          cnt_d   = CNT_W'(XLEN);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          quo_d   = negq_q ? -quo_nx : quo_nx;
          rem_d   = negr_q ? -rem_nx : rem_nx;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i && state_q != S_IDLE) state_d = S_IDLE;
  end

  assign busy_o   = state_q != S_IDLE;
  assign stall_o  = !flush_i && ((state_q == S_IDLE && start_i) || state_q == S_BUSY);
  assign valid_o  = state_q == S_DONE && !flush_i && !rst;
  assign res_sel  = op_q[1] ? rem_q : quo_q;
  assign result_o = valid_o ? res_sel : out_q;
  assign rd_addr_o = valid_o ? rd_q : ord_q;
  assign out_d    = result_o;
  assign ord_d    = rd_addr_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      out_q   <= '0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      out_q   <= out_d;
      ord_q   <= ord_d;
    end
  end
endmodule

// File: tb/tb_ex_div_sequencer.sv
// Bench for ex_div_sequencer: table vectors and random ops through a scoreboard,
// plus hand-written flush / reset / held-start sequences.
module tb_ex_div_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] rs1_i = '0, rs2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, busy_o, valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int checks = 0;
  int errors = 0;
  logic [36:0] sbq[$];

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[16];

  ex_div_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i), .stall_o(stall_o),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sbv;
    sa = a; sbv = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      return op[1] ? 32'(sa % sbv) : 32'(sa / sbv);
    end
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  // Called at a negedge; cycle 0 is the cycle in which start_i is first seen.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int cyc, nstall;
    logic got;
    logic [36:0] e;
    sbq.push_back({rd, exp});
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    cyc = 0; nstall = 0; got = 1'b0; e = '0;
    while (!got && cyc < 40) begin
      #1;
      if (stall_o) nstall++;
      if (valid_o) begin
        got = 1'b1;
        e = sbq.pop_front();
        check("result", result_o, e[31:0]);
        check("rd", 32'(rd_addr_o), 32'(e[36:32]));
        check("latency", cyc, lat);
      end
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
    end
    if (!got) begin
      check("valid_timeout", 32'(got), 32'd1);
      void'(sbq.pop_front());
    end
    check("stall_cycles", nstall, lat);
    #1;
    check("valid_one_shot", 32'(valid_o), 32'd0);
    check("idle_after_done", 32'(busy_o), 32'd0);
    check("result_hold", result_o, e[31:0]);
  endtask

  initial begin
    int nv;
    logic [1:0] rop;
    logic [31:0] ra, rb;
    vecs[0]  = '{DIVU, 32'd100,        32'd7,          5'd3,  32'd14,         33};
    vecs[1]  = '{REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  33};
    vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  33};
    vecs[3]  = '{DIV,  32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF,  1};
    vecs[4]  = '{REMU, 32'd5,          32'd0,          5'd7,  32'd5,          1};
    vecs[5]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  1};
    vecs[6]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h0,          1};
    vecs[7]  = '{DIV,  32'd7,          32'hFFFF_FFFE,  5'd10, 32'hFFFF_FFFD,  33};
    vecs[8]  = '{REM,  32'd7,          32'hFFFF_FFFE,  5'd11, 32'd1,          33};
    vecs[9]  = '{DIVU, 32'hFFFF_FFFF,  32'd1,          5'd12, 32'hFFFF_FFFF,  33};
    vecs[10] = '{REMU, 32'hFFFF_FFFF,  32'd10,         5'd13, 32'd5,          33};
    vecs[11] = '{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd14, 32'd14,         33};
    vecs[12] = '{REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd15, 32'hFFFF_FFFE,  33};
    vecs[13] = '{DIVU, 32'h8000_0000,  32'd3,          5'd16, 32'h2AAA_AAAA,  33};
    vecs[14] = '{REM,  32'hFFFF_FFFB,  32'd0,          5'd17, 32'hFFFF_FFFB,  1};
    vecs[15] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd31, 32'd0,          33};

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", 32'(rd_addr_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

    for (int k = 0; k < 20; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      rb  = (k % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom();
      if (k % 7 == 0) rb = 32'hFFFF_FFFF;
      run(rop, ra, rb, 5'(k), model(rop, ra, rb), model_lat(rop, ra, rb));
    end

    // flush in BUSY at cycle 10
    start_i = 1'b1; op_i = DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; rd_addr_i = 5'd20;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    #1;
    check("flush_stall_drop", 32'(stall_o), 32'd0);
    check("flush_no_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_idle", 32'(busy_o), 32'd0);
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (valid_o) nv++;
    end
    check("flush_no_late_valid", nv, 0);
    @(negedge clk);
    run(DIVU, 32'd1000, 32'd3, 5'd21, 32'd333, 33);

    // flush in DONE suppresses valid the same cycle
    @(negedge clk);
    start_i = 1'b1; op_i = DIVU; rs1_i = 32'd50; rs2_i = 32'd5; rd_addr_i = 5'd22;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    #1;
    check("done_flush_valid", 32'(valid_o), 32'd0);
    check("done_flush_hold", result_o, 32'd333);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("done_flush_idle", 32'(busy_o), 32'd0);

    // flush together with start in IDLE
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1;
    #1;
    check("idle_flush_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check("idle_flush_busy", 32'(busy_o), 32'd0);

    // reset in BUSY
    @(negedge clk);
    start_i = 1'b1; op_i = DIVU; rs1_i = 32'd100; rs2_i = 32'd7; rd_addr_i = 5'd23;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    check("mid_rst_rd", 32'(rd_addr_o), 32'd0);

    // start held through DONE fires once
    @(negedge clk);
    start_i = 1'b1; op_i = DIVU; rs1_i = 32'd100; rs2_i = 32'd7; rd_addr_i = 5'd24;
    nv = 0;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      #1;
      if (valid_o) nv++;
    end
    check("held_valid", 32'(valid_o), 32'd1);
    check("held_result", result_o, 32'd14);
    check("held_rd", 32'(rd_addr_o), 32'd24);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("held_not_reissued", 32'(busy_o), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (valid_o) nv++;
    end
    check("held_single_valid", nv, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
